// File: rtl/tt_tag_alloc_pkg.sv
// Shared types for the tag allocator: default-width tag and response templates.
package tt_tag_alloc_pkg;

  localparam int PKG_WIDTH      = 8;
  localparam int PKG_TAG_W      = $clog2(PKG_WIDTH);
  localparam int PKG_DATA_WIDTH = 4;

  typedef logic [PKG_TAG_W-1:0] tag_t;

  typedef struct packed {
    tag_t                      tag;
    logic [PKG_DATA_WIDTH-1:0] data;
  } rsp_t;

endpackage

// File: rtl/tt_ffs.sv
// Find-first-set: encodes the first asserted request in the chosen direction
// and forwards that lane's data.
module tt_ffs #(
  parameter int  WIDTH      = 8,
  parameter int  DATA_WIDTH = 1,
  parameter bit  DIR_L2H    = 1'b1,
  localparam int ENC_W      = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]                 req_in,
  input  logic [WIDTH-1:0][DATA_WIDTH-1:0] data_in,
  output logic                             vld_out,
  output logic [ENC_W-1:0]                 enc_out,
  output logic [DATA_WIDTH-1:0]            data_out
);

  // Priority scan; first hit in scan order wins.
  always_comb begin
    logic [ENC_W-1:0] k;
    vld_out  = 1'b0;
    enc_out  = '0;
    data_out = '0;
    k        = '0;
    for (int i = 0; i < WIDTH; i++) begin
      k = ENC_W'(DIR_L2H ? i : (WIDTH - 1 - i));
      if (!vld_out && req_in[k]) begin
        vld_out  = 1'b1;
        enc_out  = k;
        data_out = data_in[k];
      end else begin
        vld_out  = vld_out;
      end
    end
  end

endmodule

// File: rtl/tt_tag_alloc.sv
// Tag allocator with per-tag payload store; a release returns the payload
// one cycle later.
module tt_tag_alloc
  import tt_tag_alloc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int TAG_W      = $clog2(WIDTH),
  parameter int DATA_WIDTH = 4,
  parameter bit DIR_L2H    = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_alloc_req,
  input  logic [DATA_WIDTH-1:0] i_alloc_data,
  output logic                  o_alloc_gnt,
  output logic [TAG_W-1:0]      o_alloc_tag,
  input  logic                  i_rel_vld,
  input  logic [TAG_W-1:0]      i_rel_tag,
  output logic                  o_rsp_vld,
  output logic [TAG_W-1:0]      o_rsp_tag,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rel_err,
  output logic [WIDTH-1:0]      o_busy,
  output logic [TAG_W:0]        o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  logic [WIDTH-1:0]      busy_r;
  logic [WIDTH-1:0]      busy_nxt;
  logic [TAG_W:0]        count_r;
  logic [TAG_W:0]        count_nxt;
  logic [DATA_WIDTH-1:0] payload_r [WIDTH];
  logic                  rsp_vld_r;
  logic [TAG_W-1:0]      rsp_tag_r;
  logic [DATA_WIDTH-1:0] rsp_data_r;
  logic                  rel_err_r;

  logic                  ffs_vld;
  logic [TAG_W-1:0]      ffs_enc;
  logic [0:0]            ffs_data;
  logic                  alloc_fire;
  logic                  rel_hit;
  logic [WIDTH-1:0]      rel_oh;
  logic [WIDTH-1:0]      alloc_oh;

  tt_ffs #(
    .WIDTH      (WIDTH),
    .DATA_WIDTH (1),
    .DIR_L2H    (DIR_L2H)
  ) u_ffs (
    .req_in   (~busy_r),
    .data_in  ('0),
    .vld_out  (ffs_vld),
    .enc_out  (ffs_enc),
    .data_out (ffs_data)
  );

  // The data lane is tied to zero, so folding it in leaves the grant unchanged.
  assign o_alloc_gnt = ffs_vld & ~ffs_data[0];
  assign o_alloc_tag = ffs_enc;

  assign alloc_fire = i_alloc_req & o_alloc_gnt;
  assign rel_hit    = i_rel_vld & busy_r[i_rel_tag];
  assign rel_oh     = WIDTH'(1) << i_rel_tag;
  assign alloc_oh   = WIDTH'(1) << o_alloc_tag;

  // Next busy vector and occupancy; the allocated tag was free before the release.
  always_comb begin
    busy_nxt  = busy_r;
    count_nxt = count_r;
    if (rel_hit) begin
      busy_nxt = busy_nxt & ~rel_oh;
    end else begin
      busy_nxt = busy_nxt;
    end
    if (alloc_fire) begin
      busy_nxt = busy_nxt | alloc_oh;
    end else begin
      busy_nxt = busy_nxt;
    end
    if (alloc_fire && !rel_hit) begin
      count_nxt = count_r + (TAG_W+1)'(1);
    end else if (!alloc_fire && rel_hit) begin
      count_nxt = count_r - (TAG_W+1)'(1);
    end else begin
      count_nxt = count_r;
    end
  end

  // Tag state and release response registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      busy_r     <= '0;
      count_r    <= '0;
      rsp_vld_r  <= 1'b0;
      rsp_tag_r  <= '0;
      rsp_data_r <= '0;
      rel_err_r  <= 1'b0;
    end else begin
      busy_r    <= busy_nxt;
      count_r   <= count_nxt;
      rsp_vld_r <= rel_hit;
      rel_err_r <= i_rel_vld & ~busy_r[i_rel_tag];
      if (rel_hit) begin
        rsp_tag_r  <= i_rel_tag;
        rsp_data_r <= payload_r[i_rel_tag];
      end else begin
        rsp_tag_r  <= rsp_tag_r;
        rsp_data_r <= rsp_data_r;
      end
    end
  end

  // Payload store; slots are only read once written, so no reset.
  always_ff @(posedge i_clk) begin
    if (alloc_fire) begin
      payload_r[o_alloc_tag] <= i_alloc_data;
    end else begin
      payload_r[o_alloc_tag] <= payload_r[o_alloc_tag];
    end
  end

  assign o_rsp_vld  = rsp_vld_r;
  assign o_rsp_tag  = rsp_tag_r;
  assign o_rsp_data = rsp_data_r;
  assign o_rel_err  = rel_err_r;
  assign o_busy     = busy_r;
  assign o_count    = count_r;
  assign o_full     = (count_r == (TAG_W+1)'(WIDTH));
  assign o_empty    = (count_r == (TAG_W+1)'(0));

endmodule

// File: tb/tb_tt_tag_alloc.sv
// Bench for tt_tag_alloc: vector table for the low-first instance, a response
// scoreboard, plus short sequences for reset and the high-first instance.
module tb_tt_tag_alloc;

  localparam int W  = 8;
  localparam int TW = 3;
  localparam int DW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          a_req, r_vld, gnt, rsp_vld, rel_err, full, empty;
  logic [DW-1:0] a_data, rsp_data;
  logic [TW-1:0] a_tag, r_tag, rsp_tag;
  logic [W-1:0]  busy;
  logic [TW:0]   count;

  logic          h_req, h_rvld, h_gnt, h_rsp_vld, h_err, h_full, h_empty;
  logic [DW-1:0] h_data, h_rsp_data;
  logic [TW-1:0] h_tag, h_rtag, h_rsp_tag;
  logic [W-1:0]  h_busy;
  logic [TW:0]   h_count;

  tt_tag_alloc #(.WIDTH(W), .DATA_WIDTH(DW), .DIR_L2H(1'b1)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_alloc_req(a_req), .i_alloc_data(a_data),
    .o_alloc_gnt(gnt), .o_alloc_tag(a_tag),
    .i_rel_vld(r_vld), .i_rel_tag(r_tag),
    .o_rsp_vld(rsp_vld), .o_rsp_tag(rsp_tag), .o_rsp_data(rsp_data),
    .o_rel_err(rel_err), .o_busy(busy), .o_count(count),
    .o_full(full), .o_empty(empty)
  );

  tt_tag_alloc #(.WIDTH(W), .DATA_WIDTH(DW), .DIR_L2H(1'b0)) dut_h (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_alloc_req(h_req), .i_alloc_data(h_data),
    .o_alloc_gnt(h_gnt), .o_alloc_tag(h_tag),
    .i_rel_vld(h_rvld), .i_rel_tag(h_rtag),
    .o_rsp_vld(h_rsp_vld), .o_rsp_tag(h_rsp_tag), .o_rsp_data(h_rsp_data),
    .o_rel_err(h_err), .o_busy(h_busy), .o_count(h_count),
    .o_full(h_full), .o_empty(h_empty)
  );

  typedef struct {
    logic          a_req;
    logic [DW-1:0] a_data;
    logic          r_vld;
    logic [TW-1:0] r_tag;
    logic          e_gnt;
    logic [TW-1:0] e_tag;
    logic [TW:0]   e_count;
    logic          e_err;
  } vec_t;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } exp_rsp_t;

  vec_t          vecs[$];
  exp_rsp_t      sb[$];
  logic [W-1:0]  m_busy;
  logic [DW-1:0] m_pay [W];
  int            n_chk  = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ar, input logic [DW-1:0] ad, input logic rv,
                              input logic [TW-1:0] rt, input logic eg, input logic [TW-1:0] et,
                              input logic [TW:0] ec, input logic ee);
    vec_t v;
    v.a_req = ar; v.a_data = ad; v.r_vld = rv; v.r_tag = rt;
    v.e_gnt = eg; v.e_tag = et; v.e_count = ec; v.e_err = ee;
    return v;
  endfunction

  task automatic step(input vec_t v);
    exp_rsp_t e;
    exp_rsp_t got;
    @(negedge clk);
    a_req = v.a_req; a_data = v.a_data; r_vld = v.r_vld; r_tag = v.r_tag;
    #1;
    chk("alloc_gnt", gnt, v.e_gnt);
    chk("alloc_tag", a_tag, v.e_tag);
    if (v.r_vld && m_busy[v.r_tag]) begin
      e.tag  = v.r_tag;
      e.data = m_pay[v.r_tag];
      sb.push_back(e);
      m_busy[v.r_tag] = 1'b0;
    end
    if (v.a_req && v.e_gnt) begin
      m_busy[v.e_tag] = 1'b1;
      m_pay[v.e_tag]  = v.a_data;
    end
    @(posedge clk);
    #1;
    a_req = 1'b0; r_vld = 1'b0;
    chk("count", count, v.e_count);
    chk("busy", busy, m_busy);
    chk("rel_err", rel_err, v.e_err);
    chk("full", full, (v.e_count == W) ? 1 : 0);
    chk("empty", empty, (v.e_count == 0) ? 1 : 0);
    chk("rsp_vld", rsp_vld, (sb.size() != 0) ? 1 : 0);
    if (sb.size() != 0) begin
      got = sb.pop_front();
      if (rsp_vld) begin
        chk("rsp_tag", rsp_tag, got.tag);
        chk("rsp_data", rsp_data, got.data);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_req = 1'b0; a_data = '0; r_vld = 1'b0; r_tag = '0;
    h_req = 1'b0; h_data = '0; h_rvld = 1'b0; h_rtag = '0;
    m_busy = '0;

    for (int i = 0; i < W; i++) vecs.push_back(mk(1'b1, DW'(i + 1), 1'b0, 3'd0, 1'b1, TW'(i), 4'(i + 1), 1'b0));
    vecs.push_back(mk(1'b1, 4'h9, 1'b0, 3'd0, 1'b0, 3'd0, 4'd8, 1'b0));
    vecs.push_back(mk(1'b0, 4'h0, 1'b1, 3'd5, 1'b0, 3'd0, 4'd7, 1'b0));
    vecs.push_back(mk(1'b1, 4'hA, 1'b0, 3'd0, 1'b1, 3'd5, 4'd8, 1'b0));
    vecs.push_back(mk(1'b1, 4'hE, 1'b1, 3'd2, 1'b0, 3'd0, 4'd7, 1'b0));
    vecs.push_back(mk(1'b1, 4'hB, 1'b0, 3'd0, 1'b1, 3'd2, 4'd8, 1'b0));
    vecs.push_back(mk(1'b0, 4'h0, 1'b1, 3'd4, 1'b0, 3'd0, 4'd7, 1'b0));
    vecs.push_back(mk(1'b0, 4'h0, 1'b1, 3'd5, 1'b1, 3'd4, 4'd6, 1'b0));
    vecs.push_back(mk(1'b0, 4'h0, 1'b1, 3'd6, 1'b1, 3'd4, 4'd5, 1'b0));
    vecs.push_back(mk(1'b0, 4'h0, 1'b1, 3'd7, 1'b1, 3'd4, 4'd4, 1'b0));
    vecs.push_back(mk(1'b1, 4'hC, 1'b1, 3'd1, 1'b1, 3'd4, 4'd4, 1'b0));
    vecs.push_back(mk(1'b0, 4'h0, 1'b1, 3'd6, 1'b1, 3'd1, 4'd4, 1'b1));
    vecs.push_back(mk(1'b0, 4'h0, 1'b0, 3'd0, 1'b1, 3'd1, 4'd4, 1'b0));
    vecs.push_back(mk(1'b1, 4'hD, 1'b1, 3'd1, 1'b1, 3'd1, 4'd5, 1'b1));
    vecs.push_back(mk(1'b0, 4'h0, 1'b1, 3'd0, 1'b1, 3'd5, 4'd4, 1'b0));
    vecs.push_back(mk(1'b0, 4'h0, 1'b1, 3'd3, 1'b1, 3'd0, 4'd3, 1'b0));

    // Values held during reset.
    #12;
    chk("rst_gnt", gnt, 1);
    chk("rst_tag", a_tag, 0);
    chk("rst_h_tag", h_tag, 7);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rel_err", rel_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) step(vecs[i]);

    // Reset while tags 1,2,4 are busy and a release of tag 2 is being driven.
    @(negedge clk);
    r_vld = 1'b1; r_tag = 3'd2;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rsp_vld", rsp_vld, 0);
    chk("async_busy", busy, 0);
    chk("async_empty", empty, 1);
    chk("async_count", count, 0);
    chk("async_tag", a_tag, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_rsp_vld", rsp_vld, 0);
    @(negedge clk);
    r_vld = 1'b0;
    rst_n = 1'b1;
    m_busy = '0;
    sb.delete();
    step(mk(1'b1, 4'h3, 1'b0, 3'd0, 1'b1, 3'd0, 4'd1, 1'b0));
    chk("post_rst_rsp_vld", rsp_vld, 0);

    // High-first instance: alloc, free-tag error, then a valid release.
    @(negedge clk);
    h_req = 1'b1; h_data = 4'h5;
    #1;
    chk("h_gnt", h_gnt, 1);
    chk("h_tag_first", h_tag, 7);
    @(posedge clk);
    #1;
    h_req = 1'b0;
    chk("h_busy", h_busy, 8'h80);
    chk("h_count", h_count, 1);
    chk("h_tag_next", h_tag, 6);
    @(negedge clk);
    h_rvld = 1'b1; h_rtag = 3'd6;
    @(posedge clk);
    #1;
    h_rvld = 1'b0;
    chk("h_err", h_err, 1);
    chk("h_err_rsp_vld", h_rsp_vld, 0);
    chk("h_err_busy", h_busy, 8'h80);
    @(negedge clk);
    h_rvld = 1'b1; h_rtag = 3'd7;
    @(posedge clk);
    #1;
    h_rvld = 1'b0;
    chk("h_err_pulse", h_err, 0);
    chk("h_rsp_vld", h_rsp_vld, 1);
    chk("h_rsp_tag", h_rsp_tag, 7);
    chk("h_rsp_data", h_rsp_data, 5);
    chk("h_empty", h_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_tag_alloc.md
# tt_tag_alloc

Tag allocator and payload store for up to WIDTH outstanding VPU operations. An issuer gets a tag and stores a payload against it. A completer later returns the tag, and the block sends back the stored payload. Internally, a find-first-set over the free vector produces the encoded tag. The decode path, tag index to one-hot slot clear plus payload readout, is this block's own logic. It sits between instruction issue and the completion/writeback path.

## Interface
- WIDTH, 8, number of tags; power of two, ≥2
- TAG_W, $clog2(WIDTH), tag index width
- DATA_WIDTH, 4, payload bits stored per tag
- DIR_L2H, 1, 1 allocates the lowest free tag, 0 allocates the highest
- i_clk  in  1  clock, single clock domain
- i_reset_n  in  1  asynchronous, active-low reset
- i_alloc_req  in  1  request a tag this cycle
- i_alloc_data  in  DATA_WIDTH  payload written to the granted tag
- o_alloc_gnt  out  1  a tag is free; allocation occurs on i_alloc_req & o_alloc_gnt
- o_alloc_tag  out  TAG_W  tag granted this cycle
- i_rel_vld  in  1  release a tag
- i_rel_tag  in  TAG_W  tag being released
- o_rsp_vld  out  1  release response valid
- o_rsp_tag  out  TAG_W  released tag
- o_rsp_data  out  DATA_WIDTH  payload stored for the released tag
- o_rel_err  out  1  pulse: release of a tag that was not busy
- o_busy  out  WIDTH  per-tag busy vector
- o_count  out  TAG_W+1  number of busy tags
- o_full / o_empty  out  1  count==WIDTH / count==0

## Operation
- State: busy[WIDTH], payload[WIDTH][DATA_WIDTH], count, response registers.
- Allocation:
  - o_alloc_gnt = |~busy.
  - o_alloc_tag = first free index in the DIR_L2H direction; it is 0 when none are free.
  - On fire: busy[tag] is set and payload[tag] is written with i_alloc_data.
  - i_alloc_req with o_alloc_gnt=0 has no effect; the requester holds.
- Release:
  - i_rel_tag is decoded to one-hot.
  - If busy[tag]: busy[tag] is cleared and count is decremented. Next cycle: o_rsp_vld=1, o_rsp_tag=i_rel_tag, o_rsp_data=payload[tag] (the value before any same-cycle write).
  - If !busy[tag]: no state change and o_rsp_vld=0. Next cycle o_rel_err=1 for one cycle.
- Simultaneous alloc fire and valid release:
  - Both take effect and count is unchanged.
  - The allocation chooses from the pre-release free vector, so a tag released this cycle cannot be re-granted until the next cycle.
- Release of a not-busy tag equal to o_alloc_tag in the same cycle: flagged as an error; the allocation still completes.
- The payload array needs no reset. Reading an unallocated slot never produces o_rsp_vld.

## Timing
- o_alloc_gnt and o_alloc_tag are combinational from busy (registered). There is no combinational path from i_alloc_req or i_rel_* to them.
- busy, count, o_full and o_empty update at the clock edge following the fire or release.
- Release-to-response latency is 1 cycle. Back-to-back releases produce back-to-back responses.
- Reset values (asynchronous assertion, synchronous release): busy=0, count=0, o_empty=1, o_full=0, o_rsp_vld=0, o_rsp_tag=0, o_rsp_data=0, o_rel_err=0.
- Because busy=0 at reset, o_alloc_gnt=1 and o_alloc_tag equals 0 (DIR_L2H=1) or WIDTH-1 (DIR_L2H=0) during and after reset.
- Reset mid-operation drops all outstanding tags and any pending response. No response is emitted for them.
- count saturation is impossible by construction: allocation is blocked when full and releases are blocked when not busy. Verification asserts count == popcount(busy).

## Structure
- Package tt_tag_alloc_pkg holds the tag_t typedef (logic [TAG_W-1:0]) as a parameterised-width template and the rsp_t struct (tag, data).
- Free-tag search reuses the existing tt_ffs, with req_in = ~busy, DIR_L2H passed through, and data_in unused (tied to 0). It is a natural sub-module instance; do not duplicate it.
- The one-hot release decode and the payload read mux are inline.

## Test plan
- Reset, WIDTH=8, DIR_L2H=1; 8 consecutive allocs with data 0x1..0x8 -> tags 0..7 granted in order; o_full=1 and o_alloc_gnt=0 after the 8th; a 9th request is ignored.
- Release tag 5 -> next cycle o_rsp_vld=1, o_rsp_tag=5, o_rsp_data=0x6; o_count 8->7; the following alloc gets tag 5.
- From full, same cycle: alloc req plus release of tag 2 -> alloc not granted (gnt=0 pre-release); next cycle gnt=1 and tag=2.
- With tags 0..3 busy, same cycle: alloc plus release of tag 1 -> tag 4 granted and count stays 4; response for tag 1 the next cycle.
- Release of free tag 6 -> o_rel_err pulses 1 cycle, o_rsp_vld=0, busy unchanged. Repeat with DIR_L2H=0: the first alloc gets tag 7.
- Reset asserted with 3 tags busy and a release in flight -> o_rsp_vld=0, busy=0, o_empty=1 immediately (asynchronous).
